// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line fills/writebacks to a 64-bit, 4-beat burst memory port.
// Memory read beats are matched by address tag, so foreign beats on a shared return bus are skipped.
module cacheline_adapter (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  dfp_addr,
   input  logic         dfp_read,
   input  logic         dfp_write,
   input  logic [255:0] dfp_wdata,
   output logic [255:0] dfp_rdata,
   output logic         dfp_resp,
   input  logic         bmem_ready,
   output logic         read_stage,
   output logic         write_stage,
   output logic         bmem_read,
   output logic         bmem_write,
   output logic [31:0]  bmem_addr,
   output logic [63:0]  bmem_wdata,
   input  logic [31:0]  bmem_raddr,
   input  logic [63:0]  bmem_rdata,
   input  logic         bmem_rvalid,
   output logic [2:0]   o_dbg_state
);

   // Handshake: a write beat or read request is transferred on any rising edge where
   // bmem_write/bmem_read and bmem_ready are both high; read beats need only bmem_rvalid.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_REQ   = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR_BURST = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_cnt;
   logic [26:0]   r_line_addr;
   logic [255:0]  r_wdata;
   logic [255:0]  r_line;
   logic [31:0]   w_line_addr;
   logic          w_beat_hit;

   assign w_line_addr = {r_line_addr, 5'b0};
   assign w_beat_hit  = (r_state == S_RD_WAIT) && bmem_rvalid && (bmem_raddr == w_line_addr);
   assign dfp_rdata   = r_line;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 2'd0;
         r_line_addr <= 27'd0;
         r_wdata     <= 256'd0;
         r_line      <= 256'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (dfp_write) begin
                  r_line_addr <= dfp_addr[31:5];
                  r_wdata     <= dfp_wdata;
               end else if (dfp_read) begin
                  r_line_addr <= dfp_addr[31:5];
               end
            end
            S_RD_WAIT: begin
               // The 2-bit counter wraps to 0 on the last beat, leaving it clear for the next burst.
               if (w_beat_hit) begin
                  r_line[{r_cnt, 6'd0} +: 64] <= bmem_rdata;
                  r_cnt                       <= r_cnt + 2'd1;
               end
            end
            S_WR_BURST: begin
               if (bmem_ready) r_cnt <= r_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      read_stage  = 1'b0;
      write_stage = 1'b0;
      bmem_read   = 1'b0;
      bmem_write  = 1'b0;
      bmem_addr   = 32'd0;
      bmem_wdata  = 64'd0;
      dfp_resp    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dfp_write)     w_next = S_WR_BURST;
            else if (dfp_read) w_next = S_RD_REQ;
         end
         S_RD_REQ: begin
            read_stage = 1'b1;
            bmem_read  = 1'b1;
            bmem_addr  = w_line_addr;
            if (bmem_ready) w_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            read_stage = 1'b1;
            bmem_addr  = w_line_addr;
            if (w_beat_hit && (r_cnt == 2'd3)) w_next = S_DONE;
         end
         S_WR_BURST: begin
            write_stage = 1'b1;
            bmem_write  = 1'b1;
            bmem_addr   = w_line_addr;
            bmem_wdata  = r_wdata[{r_cnt, 6'd0} +: 64];
            if (bmem_ready && (r_cnt == 2'd3)) w_next = S_DONE;
         end
         S_DONE: begin
            dfp_resp = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
